// File: rtl/dcache_pkg.sv
// dcache_pkg: shared geometry constants, controller state encoding and
// address-field helpers for the direct-mapped data cache.
//   Geometry: 16 lines x 32 bytes, 32-bit byte addresses.
//   Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2].
package dcache_pkg;

    localparam int NUM_LINES  = 16;
    localparam int LINE_BYTES = 32;
    localparam int ADDR_W     = 32;
    localparam int INDEX_W    = $clog2(NUM_LINES);
    localparam int OFFSET_W   = $clog2(LINE_BYTES);
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINE_W     = LINE_BYTES * 8;
    localparam int WORD_SEL_W = OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILLED  = 2'd3
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    // Word select ignores the byte offset bits [1:0].
    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[2 +: WORD_SEL_W];
    endfunction

    // Line-aligned memory address built from a tag and an index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] idx);
        return {tag, idx, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag / valid / dirty / data storage for the direct-mapped cache.
//   clk_i, rst_i      : clock, synchronous active-low reset (valid/dirty only)
//   i_index           : line index for both read and write
//   i_word_we/_sel/_data : single 32-bit word store into the indexed line, sets dirty
//   i_fill_we/_tag/_line : whole-line refill, sets valid and clears dirty
//   o_tag/o_valid/o_dirty/o_line : combinational read of the indexed line
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    i_index,
    input  logic                  i_word_we,
    input  logic [WORD_SEL_W-1:0] i_word_sel,
    input  logic [31:0]           i_word_data,
    input  logic                  i_fill_we,
    input  logic [TAG_W-1:0]      i_fill_tag,
    input  logic [LINE_W-1:0]     i_fill_line,
    output logic [TAG_W-1:0]      o_tag,
    output logic                  o_valid,
    output logic                  o_dirty,
    output logic [LINE_W-1:0]     o_line
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    // Valid/dirty bookkeeping; a refill wins over a store to the same line.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid <= {NUM_LINES{1'b0}};
            r_dirty <= {NUM_LINES{1'b0}};
        end else if (i_fill_we) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Tag and data arrays are deliberately left uninitialised by reset.
    always_ff @(posedge clk_i) begin
        if (i_fill_we) begin
            r_tag[i_index]  <= i_fill_tag;
            r_data[i_index] <= i_fill_line;
        end else if (i_word_we) begin
            r_data[i_index][{i_word_sel, 5'd0} +: 32] <= i_word_data;
        end
    end

    assign o_tag   = r_tag[i_index];
    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_line  = r_data[i_index];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//   CPU side : req_i, we_i, addr_i, wdata_i -> rdata_o, stall_o
//   Mem side : mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o <- mem_rdata_i, mem_ack_i
//   Stats    : hit_cnt_o, miss_cnt_o (saturating counters when DCACHE_STATS_EN
//              is defined, otherwise tied to zero)
// Hits complete with no stall. A miss stalls the pipeline, writes back a dirty
// victim, fetches the line, then spends one REFILLED cycle before the held
// access completes as a hit.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    state_e              r_state;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;
    logic [31:0]         r_rdata;

    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_W-1:0]    w_index;
    logic [WORD_SEL_W-1:0] w_word;
    logic [TAG_W-1:0]      w_rd_tag;
    logic                  w_rd_valid;
    logic                  w_rd_dirty;
    logic [LINE_W-1:0]     w_rd_line;
    logic [31:0]           w_hit_word;
    logic                  w_hit;
    logic                  w_idle;
    logic                  w_store_hit;
    logic                  w_fill;

    assign w_tag       = addr_tag(addr_i);
    assign w_index     = addr_index(addr_i);
    assign w_word      = addr_word(addr_i);
    assign w_hit       = req_i & w_rd_valid & (w_rd_tag == w_tag);
    assign w_idle      = (r_state == IDLE);
    assign w_hit_word  = w_rd_line[{w_word, 5'd0} +: 32];
    assign w_store_hit = w_idle & w_hit & we_i;
    assign w_fill      = (r_state == ALLOCATE) & mem_ack_i;

    dcache_sram u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_index     (w_index),
        .i_word_we   (w_store_hit),
        .i_word_sel  (w_word),
        .i_word_data (wdata_i),
        .i_fill_we   (w_fill),
        .i_fill_tag  (w_tag),
        .i_fill_line (mem_rdata_i),
        .o_tag       (w_rd_tag),
        .o_valid     (w_rd_valid),
        .o_dirty     (w_rd_dirty),
        .o_line      (w_rd_line)
    );

    // Miss FSM; memory-side outputs are registered alongside the state so the
    // request, address and data stay stable until the ack.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {LINE_W{1'b0}};
            r_rdata     <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit && !we_i) begin
                        r_rdata <= w_hit_word;
                    end
                    if (req_i && !w_hit) begin
                        r_mem_req <= 1'b1;
                        if (w_rd_valid && w_rd_dirty) begin
                            r_state     <= WRITEBACK;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= line_addr(w_rd_tag, w_index);
                            r_mem_wdata <= w_rd_line;
                        end else begin
                            r_state    <= ALLOCATE;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= line_addr(w_tag, w_index);
                        end
                    end
                end
                WRITEBACK: begin
                    // Request stays high; only direction and address switch.
                    if (mem_ack_i) begin
                        r_state    <= ALLOCATE;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= line_addr(w_tag, w_index);
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        r_state   <= REFILLED;
                        r_mem_req <= 1'b0;
                    end
                end
                REFILLED: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational so a missing request freezes the pipe immediately.
    always_comb begin
        stall_o = 1'b1;
        case (r_state)
            IDLE:      stall_o = req_i & ~w_hit;
            WRITEBACK: stall_o = 1'b1;
            ALLOCATE:  stall_o = 1'b1;
            REFILLED:  stall_o = 1'b1;
            default:   stall_o = 1'b1;
        endcase
    end

    // Load hits bypass straight to the output; otherwise the last load value holds.
    always_comb begin
        rdata_o = r_rdata;
        if (w_idle && w_hit && !we_i) begin
            rdata_o = w_hit_word;
        end else begin
            rdata_o = r_rdata;
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        r_after_refill;

    // Saturating access counters; the completion cycle right after a refill
    // belongs to the miss and is not counted again as a hit.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_hit_cnt      <= 32'd0;
            r_miss_cnt     <= 32'd0;
            r_after_refill <= 1'b0;
        end else begin
            r_after_refill <= (r_state == REFILLED);
            if (w_idle && w_hit && !r_after_refill && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_idle && req_i && !w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scoreboard bench for dcache_ctrl. Expected memory
// transactions and load data are queued when an access is issued and checked
// when the controller produces them; a small line-memory model answers fetches.
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         req_i;
    logic         we_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .hit_cnt_o   (hit_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] line;
    } mem_txn_t;

    mem_txn_t     exp_mem[$];
    logic [31:0]  exp_rd[$];
    logic [255:0] mem_model [logic [31:0]];
    int           cmp_cnt = 0;
    int           err_cnt = 0;

    function automatic logic [255:0] pat_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) begin
            l[k*32 +: 32] = (a | (32'(k) << 2)) ^ 32'h5A5A_0000;
        end
        return l;
    endfunction

    function automatic logic [255:0] model_line(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return pat_line(a);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [255:0] l);
        mem_txn_t t;
        t.we = we; t.addr = a; t.line = l;
        exp_mem.push_back(t);
    endtask

    // Issue one CPU access at a negedge, serve memory with 'lat' cycles per
    // request, check the stall length and load data, and return at a negedge.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input int lat, input int exp_stall);
        int       stall_cnt = 0;
        int       wait_cnt  = 0;
        int       gap_cnt   = 0;
        int       cyc       = 0;
        logic     have      = 1'b0;
        mem_txn_t cur;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
        #1;
        while (stall_o === 1'b1 && cyc < 400) begin
            stall_cnt++; cyc++;
            mem_ack_i = 1'b0;
            if (mem_req_o === 1'b1) begin
                if (!have) begin
                    cmp_cnt++;
                    assert (exp_mem.size() > 0) else begin
                        err_cnt++;
                        $error("FAIL mem_unexpected: observed request at %0h, expected none", mem_addr_o);
                    end
                    if (exp_mem.size() > 0) begin
                        cur = exp_mem.pop_front();
                    end else begin
                        cur.we = mem_we_o; cur.addr = mem_addr_o; cur.line = mem_wdata_o;
                    end
                    have = 1'b1; wait_cnt = 0;
                    chk("mem_we", {255'd0, mem_we_o}, {255'd0, cur.we});
                    if (cur.we) chk("mem_wdata", mem_wdata_o, cur.line);
                end
                chk("mem_addr", {224'd0, mem_addr_o}, {224'd0, cur.addr});
                wait_cnt++;
                if (wait_cnt == lat) begin
                    mem_ack_i = 1'b1;
                    if (cur.we) mem_model[cur.addr] = mem_wdata_o;
                    else mem_rdata_i = model_line(cur.addr);
                    have = 1'b0;
                end
            end else begin
                gap_cnt++;
            end
            @(posedge clk_i); @(negedge clk_i); #1;
        end
        mem_ack_i = 1'b0;
        chk("timeout", {255'd0, (cyc >= 400)}, 256'd0);
        chk("stall_cycles", 256'(stall_cnt), 256'(exp_stall));
        if (exp_stall > 0) chk("req_gap_cycles", 256'(gap_cnt), 256'd2);
        if (!we) begin
            cmp_cnt++;
            assert (exp_rd.size() > 0) else begin
                err_cnt++;
                $error("FAIL rd_unexpected: observed load data %0h, expected none queued", rdata_o);
            end
            if (exp_rd.size() > 0) chk("rdata", {224'd0, rdata_o}, {224'd0, exp_rd.pop_front()});
        end
        @(posedge clk_i); @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
    endtask

    initial begin
        logic [255:0] line;
        int exp_hits;
        int exp_miss;
        rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 256'd0;

        // Reset state.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1;
        chk("rst_mem_req", {255'd0, mem_req_o}, 256'd0);
        chk("rst_mem_we", {255'd0, mem_we_o}, 256'd0);
        chk("rst_mem_addr", {224'd0, mem_addr_o}, 256'd0);
        chk("rst_mem_wdata", mem_wdata_o, 256'd0);
        chk("rst_rdata", {224'd0, rdata_o}, 256'd0);
        chk("rst_stall", {255'd0, stall_o}, 256'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // A stray ack while idle must be ignored.
        mem_ack_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        mem_ack_i = 1'b0; #1;
        chk("idle_ack_req", {255'd0, mem_req_o}, 256'd0);
        chk("idle_ack_stall", {255'd0, stall_o}, 256'd0);

        // Cold load, memory answers on its 10th request cycle.
        push_mem(1'b0, 32'h40, 256'd0);
        exp_rd.push_back(32'h5A5A_0040);
        access(1'b0, 32'h40, 32'd0, 10, 12);

        // Store hit then zero-latency load hit.
        access(1'b1, 32'h44, 32'hDEAD_BEEF, 1, 0);
        exp_rd.push_back(32'hDEAD_BEEF);
        access(1'b0, 32'h44, 32'd0, 1, 0);
        #1;
        chk("rdata_hold", {224'd0, rdata_o}, {224'd0, 32'hDEAD_BEEF});

        // Conflict miss on a dirty line: write-back then fetch, request held high.
        line = pat_line(32'h40);
        line[63:32] = 32'hDEAD_BEEF;
        push_mem(1'b1, 32'h40, line);
        push_mem(1'b0, 32'h240, 256'd0);
        exp_rd.push_back(32'h5A5A_0244);
        access(1'b0, 32'h244, 32'd0, 4, 10);

        // Long memory latency: everything held for 50 cycles.
        push_mem(1'b0, 32'h80, 256'd0);
        exp_rd.push_back(32'h5A5A_0080);
        access(1'b0, 32'h80, 32'd0, 50, 52);

        // Dirty the 0x240 line, then reset in the middle of its write-back.
        access(1'b1, 32'h248, 32'hCAFE_F00D, 1, 0);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h48;
        #1;
        chk("wb_miss_stall", {255'd0, stall_o}, {255'd0, 1'b1});
        @(posedge clk_i); @(negedge clk_i); #1;
        line = pat_line(32'h240);
        line[95:64] = 32'hCAFE_F00D;
        chk("wb_req", {255'd0, mem_req_o}, {255'd0, 1'b1});
        chk("wb_we", {255'd0, mem_we_o}, {255'd0, 1'b1});
        chk("wb_addr", {224'd0, mem_addr_o}, {224'd0, 32'h240});
        chk("wb_wdata", mem_wdata_o, line);
        @(posedge clk_i); @(negedge clk_i);
        rst_i = 1'b0; req_i = 1'b0;
        @(posedge clk_i); @(negedge clk_i); #1;
        chk("midrst_mem_req", {255'd0, mem_req_o}, 256'd0);
        chk("midrst_stall", {255'd0, stall_o}, 256'd0);
        chk("midrst_mem_addr", {224'd0, mem_addr_o}, 256'd0);
        chk("midrst_rdata", {224'd0, rdata_o}, 256'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // Lines are invalid now: 0x44 misses cleanly and returns the written-back word.
        push_mem(1'b0, 32'h40, 256'd0);
        exp_rd.push_back(32'hDEAD_BEEF);
        access(1'b0, 32'h44, 32'd0, 3, 5);
        exp_rd.push_back(32'h5A5A_0040);
        access(1'b0, 32'h40, 32'd0, 1, 0);
        access(1'b1, 32'h48, 32'h1234_5678, 1, 0);
        push_mem(1'b0, 32'h80, 256'd0);
        exp_rd.push_back(32'h5A5A_0080);
        access(1'b0, 32'h80, 32'd0, 2, 4);

`ifdef DCACHE_STATS_EN
        exp_hits = 2; exp_miss = 2;
`else
        exp_hits = 0; exp_miss = 0;
`endif
        #1;
        chk("hit_cnt", {224'd0, hit_cnt_o}, 256'(exp_hits));
        chk("miss_cnt", {224'd0, miss_cnt_o}, 256'(exp_miss));

        exp_rd.push_back(32'h1234_5678);
        access(1'b0, 32'h48, 32'd0, 1, 0);

        chk("sb_mem_drained", 256'(exp_mem.size()), 256'd0);
        chk("sb_rd_drained", 256'(exp_rd.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller in the MEM stage.
- Sits between the EX_MEM pipeline register (CPU side) and a multi-cycle off-chip data memory (memory side).
- Services hits with no stall. On a miss it asserts stall_o to freeze the pipeline, then runs a write-back/allocate handshake with memory.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2); INDEX_W = log2(NUM_LINES).
- LINE_BYTES, 32, bytes per line (256-bit line); OFFSET_W = 5.
- ADDR_W, 32, address width; TAG_W = ADDR_W - INDEX_W - OFFSET_W (23 by default).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-low.
- req_i  in  1  CPU memory access valid (MemRead or MemWrite from EX_MEM).
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  ADDR_W  byte address; bits [1:0] are ignored (word access).
- wdata_i  in  32  store data.
- rdata_o  out  32  load data; valid when req_i=1, we_i=0, stall_o=0.
- stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM; bubble into MEM_WB.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  ADDR_W  line-aligned address (low OFFSET_W bits zero).
- mem_wdata_o  out  256  victim line data.
- mem_rdata_i  in  256  fetched line data.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_i=0 at posedge): every valid and dirty bit cleared, state IDLE. Outputs: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, stall_o=0. Data and tag arrays are not cleared.
- Address split: tag=addr[31:9], index=addr[8:5], word=addr[4:2].
- hit = req_i & valid[index] & (tag_array[index]==tag).
- States: IDLE, WRITEBACK, ALLOCATE, REFILLED.
- stall_o = req_i & ~hit while in IDLE; 1 in WRITEBACK, ALLOCATE and REFILLED. stall_o is combinational: it asserts in the same cycle as a missing request.
- IDLE, hit:
  - Load: rdata_o = selected word, combinational, zero latency.
  - Store: the word is written at the posedge and dirty[index] is set. No stall.
- IDLE, miss: go to WRITEBACK if valid & dirty, else to ALLOCATE.
- WRITEBACK:
  - mem_req_o=1, mem_we_o=1, mem_addr_o={old_tag,index,5'b0}, mem_wdata_o=victim line.
  - On mem_ack_i go to ALLOCATE.
- ALLOCATE:
  - mem_req_o=1, mem_we_o=0, mem_addr_o={tag,index,5'b0}.
  - On mem_ack_i: line=mem_rdata_i, tag updated, valid=1, dirty=0; go to REFILLED.
- REFILLED: single cycle, mem_req_o=0; go to IDLE. The held access then hits and completes; a store sets dirty there.
- Memory handshake rules:
  - mem_req_o and its address/data are held stable until mem_ack_i.
  - mem_ack_i is ignored when mem_req_o=0.
  - mem_req_o drops in the cycle after the ack. Back-to-back WRITEBACK→ALLOCATE keeps mem_req_o high, with mem_we_o and mem_addr_o changing on that edge.
- Miss penalty: clean miss = memory latency + 2 cycles; dirty miss adds one write-back latency.
- The CPU holds req_i/we_i/addr_i/wdata_i stable while stall_o=1. The controller does not re-sample the address during a miss.
- Reset mid-miss: state returns to IDLE next edge, mem_req_o=0, the in-flight transaction is abandoned, and dirty data is lost.
- req_i=0 in IDLE: no state change, stall_o=0, rdata_o holds its last value.

Optional Feature:
- DCACHE_STATS_EN: adds 32-bit saturating counters hit_cnt_o and miss_cnt_o (output ports, always declared).
  - hit_cnt_o increments on an IDLE hit cycle with stall_o=0, counted once per access.
  - miss_cnt_o increments on the IDLE→WRITEBACK/ALLOCATE transition.
  - Both are cleared by reset.
- Without the macro: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package dcache_pkg holds:
  - state enum {IDLE, WRITEBACK, ALLOCATE, REFILLED};
  - OFFSET_W, INDEX_W, TAG_W and LINE_W=256 constants;
  - address field extract functions.
- Sub-module dcache_sram: tag/valid/dirty/data arrays.
  - Combinational read.
  - Synchronous write with word-enable and full-line write.
  - Valid/dirty are reset by rst_i.
- The FSM and hit logic stay in dcache_ctrl.

Test Plan:
- Cold load 0x0000_0040 with mem ack after 10 cycles → stall_o high for 12 cycles, one fetch at 0x40, rdata_o=fetched word 0.
- Store 0xDEADBEEF to 0x44 after that fill → no stall, dirty[2]=1. Load 0x44 → 0xDEADBEEF with zero latency.
- Load 0x0000_0244 (same index 2, different tag) → write-back at 0x40 with the modified line, then fetch at 0x240; mem_req_o stays continuously high.
- Hold mem_ack_i low for 50 cycles in ALLOCATE → mem_req_o/mem_addr_o stable and stall_o held the whole time.
- Assert rst_i=0 in the middle of WRITEBACK → next cycle mem_req_o=0, stall_o=0 and all lines invalid; a later load of 0x44 misses.
- With DCACHE_STATS_EN defined, sequence miss, hit, hit, miss → hit_cnt_o=2, miss_cnt_o=2. Without it, both read 0.
